// File: rtl/param_mac_pe_if.sv
// param_mac_pe_if: data/control bundle between a systolic row controller (master)
// and one multiply-accumulate PE (slave). Clock and reset stay outside the bundle.
interface param_mac_pe_if #(
    parameter int DW     = 8,
    parameter int WDEPTH = 4,
    parameter int ACCW   = 24,
    parameter int CNTW   = 8
);
    localparam int IW = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;

    logic                   pipe_en;
    logic signed [DW-1:0]   imap_in;
    logic signed [DW-1:0]   imap_out;
    logic signed [DW-1:0]   wt_load;
    logic                   wt_load_en;
    logic [IW-1:0]          wt_load_idx;
    logic [IW-1:0]          wt_sel;
    logic                   pe_en;
    logic [CNTW-1:0]        acc_num;
    logic                   acc_clr;
    logic signed [2*DW-1:0] product;
    logic signed [ACCW-1:0] psum;
    logic                   psum_vld;
    logic                   sat_flag;

    modport master (
        output pipe_en, imap_in, wt_load, wt_load_en, wt_load_idx, wt_sel,
               pe_en, acc_num, acc_clr,
        input  imap_out, product, psum, psum_vld, sat_flag
    );

    modport slave (
        input  pipe_en, imap_in, wt_load, wt_load_en, wt_load_idx, wt_sel,
               pe_en, acc_num, acc_clr,
        output imap_out, product, psum, psum_vld, sat_flag
    );
endinterface

// File: rtl/param_mac_pe.sv
// param_mac_pe: parametrised multiply-accumulate PE.
// imap shift register -> selectable weight buffer -> registered multiplier ->
// counted accumulator emitting one psum per group of acc_num products.
// Optional macro PE_SAT_EN: saturating accumulation with sticky sat_flag;
// when undefined the accumulator wraps and sat_flag is tied 0.
module param_mac_pe #(
    parameter int DW     = 8,
    parameter int WDEPTH = 4,
    parameter int ACCW   = 24,
    parameter int CNTW   = 8
) (
    input logic         clk,
    input logic         rst,
    param_mac_pe_if.slave pe
);
    localparam int IW = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   imap_q, imap_d;
    logic signed [DW-1:0]   wbuf_q [WDEPTH];
    logic signed [DW-1:0]   wbuf_d [WDEPTH];
    logic signed [DW-1:0]   weight;
    logic signed [2*DW-1:0] product_q, product_d;
    logic                   prod_vld_q, prod_vld_d;
    logic [CNTW-1:0]        cnt_q, cnt_d, n_q, n_d;
    logic signed [ACCW-1:0] acc_q, acc_d, psum_q, psum_d;
    logic                   psum_vld_q, psum_vld_d;

    logic signed [ACCW-1:0] prod_ext, base, sum_w;
    logic [CNTW-1:0]        grp_n, cnt_inc;
    logic                   first, done;
`ifdef PE_SAT_EN
    logic                   sat_q, sat_d;
    logic signed [ACCW:0]   sum_x;
    logic                   ovf;
`endif

    // Front end: imap shift, weight read/write and multiplier stage
    always_comb begin
        imap_d = pe.pipe_en ? pe.imap_in : imap_q;
        weight = '0;
        if (int'(pe.wt_sel) < WDEPTH) weight = wbuf_q[pe.wt_sel];
        for (int unsigned i = 0; i < WDEPTH; i++) begin
            wbuf_d[i] = wbuf_q[i];
            if (pe.wt_load_en && pe.wt_load_idx == IW'(i)) wbuf_d[i] = pe.wt_load;
        end
        product_d  = pe.pe_en ? (2*DW)'(weight) * (2*DW)'(imap_q) : '0;
        prod_vld_d = pe.pe_en;
    end

    // Accumulator datapath: group length, counter increment and (wrapped or saturated) sum
    always_comb begin
        first    = (state_q == IDLE);
        grp_n    = first ? ((pe.acc_num == '0) ? CNTW'(1) : pe.acc_num) : n_q;
        cnt_inc  = cnt_q + CNTW'(1);
        done     = (cnt_inc == grp_n);
        prod_ext = ACCW'(product_q);
        base     = first ? '0 : acc_q;
`ifdef PE_SAT_EN
        sum_x = (ACCW+1)'(base) + (ACCW+1)'(prod_ext);
        ovf   = (sum_x[ACCW] != sum_x[ACCW-1]);
        if (!ovf)              sum_w = sum_x[ACCW-1:0];
        else if (sum_x[ACCW])  sum_w = {1'b1, {(ACCW-1){1'b0}}};
        else                   sum_w = {1'b0, {(ACCW-1){1'b1}}};
`else
        sum_w = base + prod_ext;
`endif
    end

    // Counter FSM: next state, accumulator, psum and pulse
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        acc_d      = acc_q;
        psum_d     = psum_q;
        psum_vld_d = 1'b0;
`ifdef PE_SAT_EN
        sat_d      = sat_q;
`endif
        if (pe.acc_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
`ifdef PE_SAT_EN
            sat_d   = 1'b0;
`endif
        end else if (prod_vld_q) begin
            acc_d = sum_w;
            n_d   = grp_n;
`ifdef PE_SAT_EN
            if (ovf) sat_d = 1'b1;
`endif
            if (done) begin
                psum_d     = sum_w;
                psum_vld_d = 1'b1;
                cnt_d      = '0;
                state_d    = IDLE;
            end else begin
                cnt_d   = cnt_inc;
                state_d = ACCUM;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            imap_q     <= '0;
            for (int unsigned i = 0; i < WDEPTH; i++) wbuf_q[i] <= '0;
            product_q  <= '0;
            prod_vld_q <= 1'b0;
            cnt_q      <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
`ifdef PE_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            imap_q     <= imap_d;
            for (int unsigned i = 0; i < WDEPTH; i++) wbuf_q[i] <= wbuf_d[i];
            product_q  <= product_d;
            prod_vld_q <= prod_vld_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            psum_q     <= psum_d;
            psum_vld_q <= psum_vld_d;
`ifdef PE_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign pe.imap_out = imap_q;
    assign pe.product  = product_q;
    assign pe.psum     = psum_q;
    assign pe.psum_vld = psum_vld_q;
`ifdef PE_SAT_EN
    assign pe.sat_flag = sat_q;
`else
    assign pe.sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_param_mac_pe.sv
// tb_param_mac_pe: directed + randomized checks of param_mac_pe against a
// group-level reference model. Two instances: ACCW=24 (a) and ACCW=16 (b).
module tb_param_mac_pe;
    localparam int DW = 8, WDEPTH = 4, CNTW = 8;

    logic clk = 1'b0;
    logic rst, pipe_en, wt_load_en, pe_en, acc_clr;
    logic signed [DW-1:0] imap_in, wt_load;
    logic [1:0] wt_load_idx, wt_sel;
    logic [CNTW-1:0] acc_num;

    param_mac_pe_if #(.DW(DW), .WDEPTH(WDEPTH), .ACCW(24), .CNTW(CNTW)) bus_a ();
    param_mac_pe_if #(.DW(DW), .WDEPTH(WDEPTH), .ACCW(16), .CNTW(CNTW)) bus_b ();

    assign bus_a.pipe_en = pipe_en;         assign bus_b.pipe_en = pipe_en;
    assign bus_a.imap_in = imap_in;         assign bus_b.imap_in = imap_in;
    assign bus_a.wt_load = wt_load;         assign bus_b.wt_load = wt_load;
    assign bus_a.wt_load_en = wt_load_en;   assign bus_b.wt_load_en = wt_load_en;
    assign bus_a.wt_load_idx = wt_load_idx; assign bus_b.wt_load_idx = wt_load_idx;
    assign bus_a.wt_sel = wt_sel;           assign bus_b.wt_sel = wt_sel;
    assign bus_a.pe_en = pe_en;             assign bus_b.pe_en = pe_en;
    assign bus_a.acc_num = acc_num;         assign bus_b.acc_num = acc_num;
    assign bus_a.acc_clr = acc_clr;         assign bus_b.acc_clr = acc_clr;

    param_mac_pe #(.DW(DW), .WDEPTH(WDEPTH), .ACCW(24), .CNTW(CNTW)) dut_a (
        .clk(clk), .rst(rst), .pe(bus_a));
    param_mac_pe #(.DW(DW), .WDEPTH(WDEPTH), .ACCW(16), .CNTW(CNTW)) dut_b (
        .clk(clk), .rst(rst), .pe(bus_b));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state (group level)
    int     wt_m [WDEPTH];
    int     imap_m, prod_m;
    bit     pv_m, vld_m;
    int     cnt_m, n_m;
    longint sum_m [2], psum_m [2];
    bit     sat_m [2];
    int     aw [2] = '{24, 16};

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint fit(input longint v, input int w, output bit ov);
        longint lo, hi, m, r;
        lo = -(longint'(1) << (w - 1));
        hi = -lo - 1;
        m  = longint'(1) << w;
        ov = 1'b0;
`ifdef PE_SAT_EN
        r = v;
        if (v > hi) begin ov = 1'b1; r = hi; end
        if (v < lo) begin ov = 1'b1; r = lo; end
`else
        r = (v - lo) % m;
        if (r < 0) r += m;
        r += lo;
`endif
        return r;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        int  w, p_next;
        bit  ov;
        w = (int'(wt_sel) < WDEPTH) ? wt_m[wt_sel] : 0;
        p_next = pe_en ? w * imap_m : 0;
        vld_m = 1'b0;
        if (rst) begin
            foreach (wt_m[i]) wt_m[i] = 0;
            imap_m = 0; prod_m = 0; pv_m = 0; cnt_m = 0; n_m = 0;
            for (int k = 0; k < 2; k++) begin sum_m[k] = 0; psum_m[k] = 0; sat_m[k] = 0; end
        end else begin
            if (acc_clr) begin
                cnt_m = 0;
                for (int k = 0; k < 2; k++) begin sum_m[k] = 0; sat_m[k] = 0; end
            end else if (pv_m) begin
                if (cnt_m == 0) begin
                    n_m = (acc_num == 0) ? 1 : int'(acc_num);
                    for (int k = 0; k < 2; k++) sum_m[k] = 0;
                end
                for (int k = 0; k < 2; k++) begin
                    sum_m[k] = fit(sum_m[k] + prod_m, aw[k], ov);
                    if (ov) sat_m[k] = 1'b1;
                end
                cnt_m++;
                if (cnt_m == n_m) begin
                    for (int k = 0; k < 2; k++) psum_m[k] = sum_m[k];
                    vld_m = 1'b1;
                    cnt_m = 0;
                end
            end
            if (pipe_en) imap_m = imap_in;
            if (wt_load_en && int'(wt_load_idx) < WDEPTH) wt_m[wt_load_idx] = wt_load;
            prod_m = p_next;
            pv_m   = pe_en;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("a_imap_out", longint'(bus_a.imap_out), imap_m);
        check("a_product",  longint'(bus_a.product),  prod_m);
        check("a_psum_vld", longint'(bus_a.psum_vld), longint'(vld_m));
        check("a_psum",     longint'(bus_a.psum),     psum_m[0]);
        check("a_sat_flag", longint'(bus_a.sat_flag), longint'(sat_m[0]));
        check("b_product",  longint'(bus_b.product),  prod_m);
        check("b_psum_vld", longint'(bus_b.psum_vld), longint'(vld_m));
        check("b_psum",     longint'(bus_b.psum),     psum_m[1]);
        check("b_sat_flag", longint'(bus_b.sat_flag), longint'(sat_m[1]));
    endtask

    task automatic idle_inputs();
        rst = 0; pipe_en = 0; wt_load_en = 0; pe_en = 0; acc_clr = 0;
    endtask

    task automatic load_wt(input int idx, input int val);
        wt_load_en = 1; wt_load_idx = 2'(idx); wt_load = DW'(val);
        step();
        wt_load_en = 0;
    endtask

    // imap is fed one cycle ahead of the pe_en that consumes it
    task automatic run_seq(input int vals[$], output int pulses);
        pulses = 0;
        for (int i = 0; i <= vals.size(); i++) begin
            pipe_en = (i < vals.size());
            if (i < vals.size()) imap_in = DW'(vals[i]);
            pe_en = (i > 0);
            step();
            if (bus_a.psum_vld) pulses++;
        end
        pe_en = 0; pipe_en = 0;
        repeat (3) begin
            step();
            if (bus_a.psum_vld) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int vld_seen;

        // 1: reset with random inputs
        rst = 1;
        vld_seen = 0;
        repeat (2) begin
            pipe_en = 1'($urandom); wt_load_en = 1'($urandom); pe_en = 1'($urandom);
            acc_clr = 1'($urandom); imap_in = DW'($urandom); wt_load = DW'($urandom);
            wt_load_idx = 2'($urandom); wt_sel = 2'($urandom); acc_num = CNTW'($urandom);
            step();
            if (bus_a.psum_vld || bus_b.psum_vld) vld_seen++;
        end
        check("rst_psum_vld_seen", vld_seen, 0);
        idle_inputs();
        acc_num = 0; wt_sel = 0; imap_in = 0;

        // 2: weight buffers and product
        load_wt(0, 3); load_wt(1, -2); load_wt(2, 127); load_wt(3, -128);
        wt_sel = 2; imap_in = -128; pipe_en = 1;
        step();
        pipe_en = 0; pe_en = 1;
        step();
        check("t2_product", longint'(bus_a.product), -16256);
        pe_en = 0;
        repeat (2) step();

        // 3: four-product group
        load_wt(0, 1); wt_sel = 0; acc_num = 4;
        run_seq('{10, -3, 7, 1}, pulses);
        check("t3_pulses", pulses, 1);
        check("t3_psum", longint'(bus_a.psum), 15);

        // 4: acc_num 0 and 1 both give single-product groups
        acc_num = 0;
        run_seq('{5, 5, 5}, pulses);
        check("t4_n0_pulses", pulses, 3);
        check("t4_n0_psum", longint'(bus_a.psum), 5);
        acc_num = 1;
        run_seq('{5, 5, 5}, pulses);
        check("t4_n1_pulses", pulses, 3);
        check("t4_n1_psum", longint'(bus_a.psum), 5);

        // 5: abort a group with acc_clr while pe_en is held
        acc_num = 3; imap_in = 2; pipe_en = 1;
        step();
        pipe_en = 0; pe_en = 1;
        pulses = 0;
        repeat (2) begin step(); if (bus_a.psum_vld) pulses++; end
        acc_clr = 1;
        step(); if (bus_a.psum_vld) pulses++;
        acc_clr = 0;
        repeat (2) begin step(); if (bus_a.psum_vld) pulses++; end
        pe_en = 0;
        repeat (3) begin step(); if (bus_a.psum_vld) pulses++; end
        check("t5_pulses", pulses, 1);
        check("t5_psum", longint'(bus_a.psum), 6);

        // 6: overflow on the 16-bit instance
        wt_sel = 2; acc_num = 3;
        run_seq('{127, 127, 127}, pulses);
        check("t6_psum_a", longint'(bus_a.psum), 3 * 127 * 127);
`ifdef PE_SAT_EN
        check("t6_psum_b", longint'(bus_b.psum), 32767);
        check("t6_sat_b", longint'(bus_b.sat_flag), 1);
`else
        check("t6_psum_b", longint'(bus_b.psum), 3 * 127 * 127 - 65536);
        check("t6_sat_b", longint'(bus_b.sat_flag), 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            acc_clr     = ($urandom_range(0, 24) == 0);
            pipe_en     = 1'($urandom);
            pe_en       = ($urandom_range(0, 3) != 0);
            wt_load_en  = ($urandom_range(0, 3) == 0);
            wt_load_idx = 2'($urandom);
            wt_load     = DW'($urandom);
            wt_sel      = 2'($urandom);
            imap_in     = DW'($urandom);
            acc_num     = CNTW'($urandom_range(0, 5));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
